// File: rtl/ring_freq_counter.sv
// Gated frequency counter: synchronises an asynchronous ring oscillator output and counts its
// rising edges over fixed windows of GATE_CYCLES clk cycles, publishing each window's count.
module ring_freq_counter #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned GATE_CYCLES   = 50000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ring_in,
  output logic [WIDTH-1:0] value_out,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned MaxCycles =
      (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned GateW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [GateW-1:0] GateLast   = GateW'(GATE_CYCLES - 1);
  localparam logic [GateW-1:0] SettleLast = GateW'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] EdgeMax    = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure} state_e;

  state_e             state_q, state_d;
  logic [GateW-1:0]   gate_q, gate_d;
  logic [WIDTH-1:0]   edge_q, edge_d;
  logic               sat_q, sat_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic               s1_q, s2_q, s3_q;

  logic               rise;
  logic               edge_full;
  logic [WIDTH-1:0]   edge_next;
  logic               sat_next;

  assign rise      = s2_q & ~s3_q;
  assign edge_full = (edge_q == EdgeMax);
  // Saturating count including any rise in the current cycle; sat marks a lost edge.
  assign edge_next = (rise && !edge_full) ? edge_q + WIDTH'(1) : edge_q;
  assign sat_next  = sat_q | (rise & edge_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gate_q  <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      s1_q    <= ring_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        gate_d = '0;
        edge_d = '0;
        sat_d  = 1'b0;
        if (run) state_d = StSettle;
      end
      StSettle: begin
        if (!run || gate_q == SettleLast) begin
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          state_d = run ? StMeasure : StIdle;
        end else begin
          gate_d = gate_q + GateW'(1);
        end
      end
      StMeasure: begin
        if (gate_q == GateLast) begin
          // Window end publishes even if run dropped in this same cycle.
          value_d = edge_next;
          ovf_d   = sat_next;
          valid_d = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          if (!run) state_d = StIdle;
        end else if (!run) begin
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
          state_d = StIdle;
        end else begin
          gate_d = gate_q + GateW'(1);
          edge_d = edge_next;
          sat_d  = sat_next;
        end
      end
      default: begin
        gate_d  = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign value_out = value_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ring_freq_counter.sv
// Directed bench for ring_freq_counter: an 8-bit and a 4-bit instance share clk, rst, run and
// the ring input so saturation can be checked alongside the nominal counts.
module tb_ring_freq_counter;

  logic clk;
  logic rst;
  logic run;
  logic gen_ring;
  logic man_ring;
  logic manual;
  logic ring;
  int unsigned half;

  logic [7:0] value8;
  logic       valid8, ovf8, busy8;
  logic [3:0] value4;
  logic       valid4, ovf4, busy4;

  int passed;
  int total;

  typedef struct {
    int unsigned half;
    int          exp8;
    int          exp4;
    int          ovf4;
  } vec_t;

  vec_t vecs[6];

  assign ring = manual ? man_ring : gen_ring;

  ring_freq_counter #(
    .WIDTH        (8),
    .GATE_CYCLES  (100),
    .SETTLE_CYCLES(4)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .ring_in  (ring),
    .value_out(value8),
    .valid    (valid8),
    .overflow (ovf8),
    .busy     (busy8)
  );

  ring_freq_counter #(
    .WIDTH        (4),
    .GATE_CYCLES  (100),
    .SETTLE_CYCLES(4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .ring_in  (ring),
    .value_out(value4),
    .valid    (valid4),
    .overflow (ovf4),
    .busy     (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ring toggles land 3 ns before a clk rising edge, so whole-period windows count exactly.
  initial begin
    gen_ring = 1'b0;
    #2;
    forever begin
      if (half == 0) #10;
      else begin
        #(half);
        gen_ring = ~gen_ring;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid8 && n < 400);
    if (!valid8) check("valid_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int bad;

    vecs[0] = '{20, 25, 15, 1};
    vecs[1] = '{100, 5, 5, 0};
    vecs[2] = '{250, 2, 2, 0};
    vecs[3] = '{500, 1, 1, 0};
    vecs[4] = '{0, 0, 0, 0};
    vecs[5] = '{50, 10, 10, 0};

    passed   = 0;
    total    = 0;
    half     = 30;
    manual   = 1'b0;
    man_ring = 1'b0;
    run      = 1'b0;
    rst      = 1'b1;

    // Reset, then idle with ring toggling and run low.
    repeat (2) @(negedge clk);
    check("rst_value", value8, 0);
    check("rst_valid", valid8, 0);
    check("rst_overflow", ovf8, 0);
    check("rst_busy", busy8, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (value8 != 0 || valid8 || ovf8 || busy8 || value4 != 0 || valid4 || ovf4 || busy4)
        bad++;
    end
    check("idle_quiet", bad, 0);

    // Nominal: 100 ns ring period, 10 rises per window.
    half = 50;
    repeat (10) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("settle_busy", busy8, 1);
    wait_valid(n);
    check("first_valid_latency", n + 1, 105);
    check("nominal_value", value8, 10);
    check("nominal_overflow", ovf8, 0);
    check("nominal_value_w4", value4, 10);
    @(negedge clk);
    check("valid_one_cycle", valid8, 0);
    wait_valid(n);
    check("valid_spacing", n, 99);
    check("nominal_value_2", value8, 10);

    // Table: change ring rate, discard the mixed window, check the next one.
    for (int r = 0; r < 6; r++) begin
      if (vecs[r].half == 0) begin
        manual   = 1'b1;
        man_ring = 1'b0;
      end else begin
        manual = 1'b0;
        half   = vecs[r].half;
      end
      wait_valid(n);
      wait_valid(n);
      check($sformatf("vec%0d_value8", r), value8, vecs[r].exp8);
      check($sformatf("vec%0d_ovf8", r), ovf8, 0);
      check($sformatf("vec%0d_valid4", r), valid4, 1);
      check($sformatf("vec%0d_value4", r), value4, vecs[r].exp4);
      check($sformatf("vec%0d_ovf4", r), ovf4, vecs[r].ovf4);
    end

    // Abort at gate count 50 after a published 10.
    repeat (50) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("abort_busy", busy8, 0);
    check("abort_valid", valid8, 0);
    check("abort_value_held", value8, 10);
    check("abort_ovf_w4_held", ovf4, 0);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (valid8 || value8 != 10) bad++;
    end
    check("abort_no_publish", bad, 0);
    run = 1'b1;
    @(negedge clk);
    check("rerun_busy", busy8, 1);
    wait_valid(n);
    check("rerun_latency", n + 1, 105);
    check("rerun_value", value8, 10);

    // Reset pulsed mid-window with run held high.
    repeat (70) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_value", value8, 0);
    check("midrst_valid", valid8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_value_w4", value4, 0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_busy", busy8, 1);
    wait_valid(n);
    check("postrst_latency", n + 1, 105);
    check("postrst_value", value8, 10);

    // A single rise detected on gate count 99 belongs to the closing window.
    run      = 1'b0;
    manual   = 1'b1;
    man_ring = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    repeat (101) @(posedge clk);
    #2;
    man_ring = 1'b1;
    wait_valid(n);
    check("end_edge_counted", value8, 1);
    check("end_edge_ovf", ovf8, 0);
    repeat (20) @(negedge clk);
    man_ring = 1'b0;
    wait_valid(n);
    check("end_edge_not_next", value8, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ring_freq_counter.md
Name: ring_freq_counter

Overview:
- Gated frequency counter between the ring oscillator output and the 7-segment display interface.
- Synchronises the free-running ring output into the system clock domain and counts its rising edges over a fixed gate window of clk cycles.
- Publishes each window's count as a stable WIDTH-bit value with a one-cycle valid strobe and an overflow flag; the display shows it directly.

Parameters:
- WIDTH, 16: width of the edge counter and value_out.
- GATE_CYCLES, 50000: gate window length in clk cycles (1 ms at 50 MHz); legal range ≥ 2.
- SETTLE_CYCLES, 4: clk cycles discarded after run rises, before the first window; legal range ≥ 3.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- run  input  1  measurement enable, synchronous to clk.
- ring_in  input  1  ring oscillator output, asynchronous to clk.
- value_out  output  WIDTH  edge count of the last completed window.
- valid  output  1  one-cycle pulse when value_out updates.
- overflow  output  1  set when the last completed window saturated.
- busy  output  1  high in SETTLE and MEASURE states.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - value_out, valid, overflow, busy, edge counter, gate counter and all synchroniser/edge flops go to 0.
  - Reset asserted mid-window aborts the window with no publish.
- Synchroniser:
  - ring_in passes through 2 flops (s1, s2), then a third flop s3.
  - rise = s2 & ~s3.
  - Detection latency is 2-3 clk cycles.
  - ring_in must have high and low phases each longer than one clk period. Faster inputs under-count; this is a documented limit, not an error.
- States:
  - IDLE: busy=0, counters held at 0. Go to SETTLE when run=1.
  - SETTLE: the gate counter counts 0..SETTLE_CYCLES-1 and rises are ignored. On the last cycle, clear both counters and go to MEASURE.
  - MEASURE: the gate counter increments every cycle. Each rise increments the edge counter.
    - The edge counter saturates at 2^WIDTH-1 and sets an internal sat bit; it never wraps.
    - On the cycle where gate counter == GATE_CYCLES-1 (the window end), including any rise in that same cycle:
      - value_out <= final count, saturated.
      - overflow <= sat.
      - valid=1 on the next cycle, for exactly one cycle.
      - Edge counter, sat and gate counter clear to 0; the next window starts immediately with no gap.
  - A window is exactly GATE_CYCLES clk cycles. Back-to-back windows are spaced GATE_CYCLES cycles apart, valid to valid.
- run=0 in SETTLE or MEASURE:
  - Go to IDLE on the next edge and clear the counters.
  - The partial window is discarded: no valid, and value_out/overflow hold their last published values.
- run=0 on the exact window-end cycle: the window completes and publishes, then the block goes to IDLE.
- value_out and overflow change only on publish or rst. They stay stable between publishes, so the display samples them without a handshake.
- Gate and edge counters are unsigned. Gate counter width is ceil(log2(max(GATE_CYCLES, SETTLE_CYCLES))).

Test Plan (WIDTH=8, GATE_CYCLES=100, SETTLE_CYCLES=4, clk period 10 ns):
- Reset then idle: rst 1→0, run=0, ring toggling every 30 ns -> value_out=0, valid=0, overflow=0, busy=0 indefinitely.
- Nominal count: run=1, ring period 100 ns (1 rise per 10 clk) -> first valid 104+pipeline cycles after run; value_out=10 (±1 for phase); subsequent valids every 100 cycles; overflow=0.
- Saturation: WIDTH=4, ring period 40 ns (25 rises per window) -> value_out=15, overflow=1; then ring period 200 ns -> next window value_out=5, overflow=0.
- Abort: run drops at gate count 50 with a prior published value of 10 -> no valid, value_out stays 10, busy=0 next cycle; run re-raised -> SETTLE of 4 cycles, then a fresh window.
- Reset mid-window: rst pulsed at gate count 70 -> all outputs 0 next cycle, state IDLE; with run held 1, the block re-enters SETTLE after rst deasserts.
- Edge at window end: ring rise timed to be detected on gate count 99 -> counted in the current window's value_out, not the next window's.
